// File: rtl/reg_file_v2.sv
// Two-read/one-write register file with a sequential clear sweep after reset.
// Optional same-cycle write-to-read bypass when REG_FILE_BYPASS_EN is defined.
//
//   state    | meaning
//   ST_CLEAR | zeroing mem[clr_cnt] one entry per edge; reads forced to 0, busy=1
//   ST_RUN   | normal operation; writes accepted, reads return stored data
module reg_file_v2 #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [ADDR_W-1:0] r2_addr,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_ctrl,
  output logic [DATA_W-1:0] r1_out,
  output logic [DATA_W-1:0] r2_out,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  logic              state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = write_addr;
    mem_wdata = write_data;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (&clr_cnt_q) begin
        state_d = ST_RUN;
      end
    end else begin
      // Writes to register 0 are discarded when it is hardwired to zero.
      if (write_ctrl && !((ZERO_REG != 0) && (write_addr == '0))) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy = (state_q == ST_CLEAR);

  // The zero-register override is applied last so it also suppresses bypass.
  always_comb begin
    r1_out = '0;
    if (state_q == ST_RUN) begin
      r1_out = mem_q[r1_addr];
`ifdef REG_FILE_BYPASS_EN
      if (write_ctrl && (write_addr == r1_addr)) begin
        r1_out = write_data;
      end
`endif
      if ((ZERO_REG != 0) && (r1_addr == '0)) begin
        r1_out = '0;
      end
    end
  end

  always_comb begin
    r2_out = '0;
    if (state_q == ST_RUN) begin
      r2_out = mem_q[r2_addr];
`ifdef REG_FILE_BYPASS_EN
      if (write_ctrl && (write_addr == r2_addr)) begin
        r2_out = write_data;
      end
`endif
      if ((ZERO_REG != 0) && (r2_addr == '0)) begin
        r2_out = '0;
      end
    end
  end

endmodule
